ahb_lite_master_bfm: RTL and testbench

- Single-outstanding AHB-Lite master for testbench and bring-up use.
- Drives the AHB slave models and CoreGPIO AHB ports from a simple command/response interface.
- Converts each accepted command into one NONSEQ SINGLE transfer and honours HREADY wait states and the two-cycle HRESP error.
- Returns read data and a status code, with an optional watchdog against a stalled slave.

---
 rtl/ahb_lite_master_bfm_if.sv | 48 ++++
 rtl/ahb_lite_master_bfm.sv | 181 ++++++++++++++++++
 tb/tb_ahb_lite_master_bfm.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_bfm_if.sv
// Command/response and AHB-Lite bus bundle for the single-outstanding master BFM.
// The master modport is the BFM's view. The slave modport is the view of whoever
// issues commands and models the AHB slave.
interface ahb_lite_master_bfm_if #(
   parameter int AWIDTH = 32
) ();

   // Command side
   logic              CMD_VALID;
   logic              CMD_READY;
   logic              CMD_WRITE;
   logic [AWIDTH-1:0] CMD_ADDR;
   logic [2:0]        CMD_SIZE;
   logic [31:0]       CMD_WDATA;

   // Response side
   logic              RSP_VALID;
   logic [31:0]       RSP_RDATA;
   logic [1:0]        RSP_STATUS;

   // AHB-Lite bus
   logic [AWIDTH-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic              HMASTLOCK;
   logic [3:0]        HPROT;
   logic [31:0]       HWDATA;
   logic [31:0]       HRDATA;
   logic              HREADY;
   logic              HRESP;

   modport master (
      input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
      input  HRDATA, HREADY, HRESP,
      output CMD_READY, RSP_VALID, RSP_RDATA, RSP_STATUS,
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
   );

   modport slave (
      output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
      output HRDATA, HREADY, HRESP,
      input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_STATUS,
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
   );

endinterface

// File: rtl/ahb_lite_master_bfm.sv
// Single-outstanding AHB-Lite master BFM.
// Each accepted command becomes one NONSEQ SINGLE transfer. The BFM honours
// HREADY wait states and the two-cycle HRESP error, then returns read data and a
// status code through a one-cycle response strobe. An optional watchdog aborts a
// data phase that a slave stalls forever.
// Status codes: 00 OKAY, 01 ERROR, 10 TIMEOUT, 11 ILLEGAL.
module ahb_lite_master_bfm #(
   parameter int          AWIDTH    = 32,
   parameter int unsigned TIMEOUT   = 256,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input logic                     HCLK,
   input logic                     HRESETN,
   ahb_lite_master_bfm_if.master   bus
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] ST_OKAY    = 2'b00;
   localparam logic [1:0] ST_ERROR   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_ILLEGAL = 2'b11;

   // A TIMEOUT of zero turns the watchdog off. The counter holds the number of
   // wait cycles already seen, so the abort fires on the cycle that would make
   // the count equal TIMEOUT.
   localparam bit          WD_EN   = (TIMEOUT != 0);
   localparam logic [31:0] WD_LAST = TIMEOUT - 1;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      RESP
   } state_t;

   state_t            state;

   logic              cmd_ready_r;
   logic              rsp_valid_r;
   logic [31:0]       rsp_rdata_r;
   logic [1:0]        rsp_status_r;

   logic [AWIDTH-1:0] haddr_r;
   logic [1:0]        htrans_r;
   logic              hwrite_r;
   logic [2:0]        hsize_r;
   logic [31:0]       hwdata_r;
   logic [31:0]       wdata_r;
   logic [31:0]       wd_cnt;

   logic              cmd_illegal;
   logic [31:0]       wdata_lanes;
   logic [31:0]       rd_shifted;
   logic [31:0]       rd_aligned;

   // The size must be byte, halfword or word, and the address must be aligned to it.
   assign cmd_illegal = (bus.CMD_SIZE > 3'd2)
                     || ((bus.CMD_SIZE == 3'd1) && bus.CMD_ADDR[0])
                     || ((bus.CMD_SIZE == 3'd2) && (bus.CMD_ADDR[1:0] != 2'b00));

   // Replicate narrow write data across all byte lanes, so the slave finds it on
   // the lane that the address selects.
   always_comb begin
      wdata_lanes = wdata_r;
      case (hsize_r)
         3'd0:    wdata_lanes = {4{wdata_r[7:0]}};
         3'd1:    wdata_lanes = {2{wdata_r[15:0]}};
         default: wdata_lanes = wdata_r;
      endcase
   end

   // Move the addressed read lane down to bit 0 and zero the bytes above the transfer size.
   always_comb begin
      rd_shifted = bus.HRDATA >> {haddr_r[1:0], 3'b000};
      rd_aligned = rd_shifted;
      case (hsize_r)
         3'd0:    rd_aligned = {24'h000000, rd_shifted[7:0]};
         3'd1:    rd_aligned = {16'h0000, rd_shifted[15:0]};
         default: rd_aligned = rd_shifted;
      endcase
   end

   // Transfer sequencer. Every bus and response output is a register set here.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state        <= IDLE;
         cmd_ready_r  <= 1'b1;
         rsp_valid_r  <= 1'b0;
         rsp_rdata_r  <= 32'h0;
         rsp_status_r <= ST_OKAY;
         haddr_r      <= '0;
         htrans_r     <= HTRANS_IDLE;
         hwrite_r     <= 1'b0;
         hsize_r      <= 3'd0;
         hwdata_r     <= 32'h0;
         wdata_r      <= 32'h0;
         wd_cnt       <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               rsp_valid_r <= 1'b0;
               if (bus.CMD_VALID) begin
                  cmd_ready_r <= 1'b0;
                  if (cmd_illegal) begin
                     rsp_valid_r  <= 1'b1;
                     rsp_status_r <= ST_ILLEGAL;
                     rsp_rdata_r  <= 32'h0;
                     state        <= RESP;
                  end else begin
                     haddr_r  <= bus.CMD_ADDR;
                     hwrite_r <= bus.CMD_WRITE;
                     hsize_r  <= bus.CMD_SIZE;
                     wdata_r  <= bus.CMD_WDATA;
                     htrans_r <= HTRANS_NONSEQ;
                     state    <= ADDR;
                  end
               end
            end

            ADDR: begin
               if (bus.HREADY) begin
                  htrans_r <= HTRANS_IDLE;
                  if (hwrite_r) begin
                     hwdata_r <= wdata_lanes;
                  end
                  wd_cnt <= 32'h0;
                  state  <= DATA;
               end
            end

            DATA: begin
               if (bus.HREADY) begin
                  rsp_valid_r <= 1'b1;
                  state       <= RESP;
                  if (bus.HRESP) begin
                     rsp_status_r <= ST_ERROR;
                     rsp_rdata_r  <= 32'h0;
                  end else begin
                     rsp_status_r <= ST_OKAY;
                     rsp_rdata_r  <= hwrite_r ? 32'h0 : rd_aligned;
                  end
               end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                  rsp_valid_r  <= 1'b1;
                  rsp_status_r <= ST_TIMEOUT;
                  rsp_rdata_r  <= 32'h0;
                  hwdata_r     <= 32'h0;
                  state        <= RESP;
               end else begin
                  wd_cnt <= wd_cnt + 32'd1;
               end
            end

            RESP: begin
               rsp_valid_r <= 1'b0;
               cmd_ready_r <= 1'b1;
               state       <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.CMD_READY  = cmd_ready_r;
   assign bus.RSP_VALID  = rsp_valid_r;
   assign bus.RSP_RDATA  = rsp_rdata_r;
   assign bus.RSP_STATUS = rsp_status_r;
   assign bus.HADDR      = haddr_r;
   assign bus.HTRANS     = htrans_r;
   assign bus.HWRITE     = hwrite_r;
   assign bus.HSIZE      = hsize_r;
   assign bus.HWDATA     = hwdata_r;
   assign bus.HBURST     = 3'b000;
   assign bus.HMASTLOCK  = 1'b0;
   assign bus.HPROT      = HPROT_VAL;

endmodule

// File: tb/tb_ahb_lite_master_bfm.sv
// Directed bench for ahb_lite_master_bfm. The bench drives the command port and
// plays the AHB slave through HREADY/HRESP/HRDATA. Inputs change and outputs are
// sampled on the falling edge.
module tb_ahb_lite_master_bfm;

   logic HCLK = 1'b0;
   logic HRESETN;

   int checks = 0;
   int errors = 0;
   int cyc_since = 0;
   int nonseq_cnt = 0;
   int ns_before = 0;

   ahb_lite_master_bfm_if #(.AWIDTH(32)) bus ();

   ahb_lite_master_bfm #(
      .AWIDTH    (32),
      .TIMEOUT   (8),
      .HPROT_VAL (4'b0011)
   ) dut (
      .HCLK    (HCLK),
      .HRESETN (HRESETN),
      .bus     (bus)
   );

   // Free-running 100 MHz clock
   always #5 HCLK = ~HCLK;

   // Count address phases the slave would accept as NONSEQ
   always @(posedge HCLK) begin
      if (bus.HTRANS === 2'b10 && bus.HREADY === 1'b1) nonseq_cnt++;
   end

   // Hard stop in case the sequence ever hangs
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   task automatic cyc();
      @(negedge HCLK);
      cyc_since++;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present one command for one cycle; returns at the falling edge after acceptance
   task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata);
      checkOutput({tag, "_ready"}, 32'(bus.CMD_READY), 32'd1);
      ns_before = nonseq_cnt;
      bus.CMD_VALID = 1'b1;
      bus.CMD_WRITE = wr;
      bus.CMD_ADDR  = addr;
      bus.CMD_SIZE  = size;
      bus.CMD_WDATA = wdata;
      cyc_since = 0;
      cyc();
      bus.CMD_VALID = 1'b0;
      bus.CMD_WDATA = 32'hFFFF_FFFF;
      bus.CMD_ADDR  = 32'hFFFF_FFFF;
   endtask

   // Wait, bounded, for the response strobe and check its latency from acceptance
   task automatic waitRsp(input string tag, input int exp_lat);
      while (bus.RSP_VALID !== 1'b1 && cyc_since < 60) cyc();
      checkOutput({tag, "_lat"}, 32'(cyc_since), 32'(exp_lat));
   endtask

   // Check the strobe drops and the block is ready again
   task automatic finishRsp(input string tag);
      cyc();
      checkOutput({tag, "_vld_low"}, 32'(bus.RSP_VALID), 32'd0);
      checkOutput({tag, "_rdy_back"}, 32'(bus.CMD_READY), 32'd1);
   endtask

   initial begin
      HRESETN       = 1'b0;
      bus.CMD_VALID = 1'b0;
      bus.CMD_WRITE = 1'b0;
      bus.CMD_ADDR  = 32'h0;
      bus.CMD_SIZE  = 3'd0;
      bus.CMD_WDATA = 32'h0;
      bus.HRDATA    = 32'h0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = 1'b0;

      // Reset values
      cyc();
      cyc();
      checkOutput("rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
      checkOutput("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      checkOutput("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
      checkOutput("rst_rsp_status", 32'(bus.RSP_STATUS), 32'd0);
      checkOutput("rst_htrans", 32'(bus.HTRANS), 32'd0);
      checkOutput("rst_haddr", bus.HADDR, 32'h0);
      checkOutput("rst_hwrite", 32'(bus.HWRITE), 32'd0);
      checkOutput("rst_hsize", 32'(bus.HSIZE), 32'd0);
      checkOutput("rst_hwdata", bus.HWDATA, 32'h0);
      checkOutput("hburst", 32'(bus.HBURST), 32'd0);
      checkOutput("hmastlock", 32'(bus.HMASTLOCK), 32'd0);
      checkOutput("hprot", 32'(bus.HPROT), 32'h3);
      HRESETN = 1'b1;
      cyc();

      // Word write 0xDEADBEEF @0x100, zero wait
      $display("[TB] word write/read");
      applyStimulus("wr_w", 1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF);
      checkOutput("wr_w_htrans", 32'(bus.HTRANS), 32'h2);
      checkOutput("wr_w_haddr", bus.HADDR, 32'h100);
      checkOutput("wr_w_hwrite", 32'(bus.HWRITE), 32'd1);
      checkOutput("wr_w_hsize", 32'(bus.HSIZE), 32'd2);
      checkOutput("wr_w_busy", 32'(bus.CMD_READY), 32'd0);
      cyc();
      checkOutput("wr_w_htrans_dp", 32'(bus.HTRANS), 32'h0);
      checkOutput("wr_w_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
      waitRsp("wr_w", 3);
      checkOutput("wr_w_status", 32'(bus.RSP_STATUS), 32'd0);
      checkOutput("wr_w_rdata", bus.RSP_RDATA, 32'h0);
      checkOutput("wr_w_nonseq", 32'(nonseq_cnt - ns_before), 32'd1);
      finishRsp("wr_w");

      // Word read @0x100, slave returns 0xDEADBEEF
      bus.HRDATA = 32'hDEAD_BEEF;
      applyStimulus("rd_w", 1'b0, 32'h100, 3'd2, 32'h0);
      checkOutput("rd_w_hwrite", 32'(bus.HWRITE), 32'd0);
      waitRsp("rd_w", 3);
      checkOutput("rd_w_status", 32'(bus.RSP_STATUS), 32'd0);
      checkOutput("rd_w_rdata", bus.RSP_RDATA, 32'hDEAD_BEEF);
      checkOutput("rd_w_nonseq", 32'(nonseq_cnt - ns_before), 32'd1);
      finishRsp("rd_w");

      // Byte write 0xA5 @0x103 with junk in the upper bits
      $display("[TB] byte/half lanes");
      applyStimulus("wr_b", 1'b1, 32'h103, 3'd0, 32'h1234_56A5);
      checkOutput("wr_b_hsize", 32'(bus.HSIZE), 32'd0);
      checkOutput("wr_b_haddr", bus.HADDR, 32'h103);
      cyc();
      checkOutput("wr_b_hwdata", bus.HWDATA, 32'hA5A5_A5A5);
      waitRsp("wr_b", 3);
      finishRsp("wr_b");

      // Halfword write 0xBEEF @0x2
      applyStimulus("wr_h", 1'b1, 32'h2, 3'd1, 32'hCAFE_BEEF);
      cyc();
      checkOutput("wr_h_hwdata", bus.HWDATA, 32'hBEEF_BEEF);
      waitRsp("wr_h", 3);
      finishRsp("wr_h");

      // Byte read @0x101 from 0x12345678 selects 0x56
      bus.HRDATA = 32'h1234_5678;
      applyStimulus("rd_b", 1'b0, 32'h101, 3'd0, 32'h0);
      waitRsp("rd_b", 3);
      checkOutput("rd_b_rdata", bus.RSP_RDATA, 32'h0000_0056);
      finishRsp("rd_b");

      // Halfword read @0x102 from 0x12345678 selects 0x1234
      applyStimulus("rd_h", 1'b0, 32'h102, 3'd1, 32'h0);
      waitRsp("rd_h", 3);
      checkOutput("rd_h_rdata", bus.RSP_RDATA, 32'h0000_1234);
      checkOutput("rd_h_status", 32'(bus.RSP_STATUS), 32'd0);
      finishRsp("rd_h");

      // Illegal: misaligned word read @0x102, no bus activity
      $display("[TB] illegal commands");
      applyStimulus("ill_w", 1'b0, 32'h102, 3'd2, 32'h0);
      waitRsp("ill_w", 1);
      checkOutput("ill_w_status", 32'(bus.RSP_STATUS), 32'd3);
      checkOutput("ill_w_rdata", bus.RSP_RDATA, 32'h0);
      checkOutput("ill_w_htrans", 32'(bus.HTRANS), 32'h0);
      finishRsp("ill_w");
      checkOutput("ill_w_nonseq", 32'(nonseq_cnt - ns_before), 32'd0);

      // Illegal: misaligned halfword and oversize
      applyStimulus("ill_h", 1'b1, 32'h101, 3'd1, 32'h0);
      waitRsp("ill_h", 1);
      checkOutput("ill_h_status", 32'(bus.RSP_STATUS), 32'd3);
      finishRsp("ill_h");
      applyStimulus("ill_s", 1'b0, 32'h0, 3'd3, 32'h0);
      waitRsp("ill_s", 1);
      checkOutput("ill_s_status", 32'(bus.RSP_STATUS), 32'd3);
      finishRsp("ill_s");
      checkOutput("ill_s_nonseq", 32'(nonseq_cnt - ns_before), 32'd0);

      // Five data-phase wait states on a write
      $display("[TB] wait states");
      applyStimulus("ws", 1'b1, 32'h40, 3'd2, 32'h0BAD_F00D);
      for (int i = 0; i < 5; i++) begin
         cyc();
         bus.HREADY = 1'b0;
         checkOutput("ws_hwdata_hold", bus.HWDATA, 32'h0BAD_F00D);
         checkOutput("ws_no_rsp", 32'(bus.RSP_VALID), 32'd0);
      end
      cyc();
      bus.HREADY = 1'b1;
      waitRsp("ws", 8);
      checkOutput("ws_status", 32'(bus.RSP_STATUS), 32'd0);
      finishRsp("ws");

      // Two-cycle error response on a read
      $display("[TB] error response");
      bus.HRDATA = 32'hFFFF_FFFF;
      applyStimulus("err", 1'b0, 32'h200, 3'd2, 32'h0);
      cyc();
      bus.HREADY = 1'b0;
      bus.HRESP  = 1'b1;
      checkOutput("err_htrans_1", 32'(bus.HTRANS), 32'h0);
      cyc();
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b1;
      checkOutput("err_htrans_2", 32'(bus.HTRANS), 32'h0);
      checkOutput("err_no_rsp", 32'(bus.RSP_VALID), 32'd0);
      waitRsp("err", 4);
      bus.HRESP = 1'b0;
      checkOutput("err_status", 32'(bus.RSP_STATUS), 32'd1);
      checkOutput("err_rdata", bus.RSP_RDATA, 32'h0);
      finishRsp("err");

      // Watchdog: HREADY stuck low through the data phase, TIMEOUT=8
      $display("[TB] watchdog timeout");
      applyStimulus("to", 1'b1, 32'h300, 3'd2, 32'h55AA_55AA);
      cyc();
      bus.HREADY = 1'b0;
      waitRsp("to", 10);
      checkOutput("to_status", 32'(bus.RSP_STATUS), 32'd2);
      checkOutput("to_hwdata", bus.HWDATA, 32'h0);
      checkOutput("to_rdata", bus.RSP_RDATA, 32'h0);
      bus.HREADY = 1'b1;
      finishRsp("to");

      // Reset during the data phase of a write
      $display("[TB] reset mid-transfer");
      applyStimulus("mrst", 1'b1, 32'h400, 3'd2, 32'h0000_0077);
      cyc();
      bus.HREADY = 1'b0;
      cyc();
      HRESETN = 1'b0;
      #1;
      checkOutput("mrst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
      checkOutput("mrst_htrans", 32'(bus.HTRANS), 32'd0);
      checkOutput("mrst_haddr", bus.HADDR, 32'h0);
      checkOutput("mrst_hwrite", 32'(bus.HWRITE), 32'd0);
      checkOutput("mrst_hwdata", bus.HWDATA, 32'h0);
      checkOutput("mrst_status", 32'(bus.RSP_STATUS), 32'd0);
      checkOutput("mrst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      cyc();
      HRESETN    = 1'b1;
      bus.HREADY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checkOutput("mrst_no_rsp", 32'(bus.RSP_VALID), 32'd0);
      end
      checkOutput("mrst_ready_after", 32'(bus.CMD_READY), 32'd1);

      // The block works normally after the reset
      bus.HRDATA = 32'hCAFE_F00D;
      applyStimulus("post", 1'b0, 32'h8, 3'd2, 32'h0);
      waitRsp("post", 3);
      checkOutput("post_rdata", bus.RSP_RDATA, 32'hCAFE_F00D);
      checkOutput("post_status", 32'(bus.RSP_STATUS), 32'd0);
      finishRsp("post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
